// File: rtl/seq_tx_0110.sv
// seq_tx_0110: serial pattern transmitter sending num_frames copies of PAT, MSB first,
// separated by gap idle cycles, with abort and a completed-frame count.
module seq_tx_0110 #(
   parameter int               PAT_W    = 4,
   parameter logic [PAT_W-1:0] PAT      = 4'b0110,
   parameter int               CNT_W    = 8,
   parameter int               GAP_W    = 4,
   parameter logic             IDLE_BIT = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [CNT_W-1:0] num_frames,
   input  logic [GAP_W-1:0] gap,
   input  logic             abort,
   output logic             out,
   output logic             out_valid,
   output logic             busy,
   output logic             done,
   output logic [CNT_W-1:0] frames_sent
);
   localparam int IW = (PAT_W > 1) ? $clog2(PAT_W) : 1;
   localparam logic [IW-1:0] MSB = IW'(PAT_W - 1);

   typedef enum logic [1:0] {IDLE, SEND, GAP, DONE} state_t;

   state_t           state, state_n;
   logic [IW-1:0]    idx, idx_n;
   logic [CNT_W-1:0] nf, nf_n, fs_n;
   logic [GAP_W-1:0] gp, gp_n, gcnt, gcnt_n;

   always_comb begin
      state_n = state;
      idx_n   = idx;
      nf_n    = nf;
      gp_n    = gp;
      gcnt_n  = gcnt;
      fs_n    = frames_sent;
      case (state)
         IDLE:
            if (start && num_frames != '0) begin
               state_n = SEND;
               nf_n    = num_frames;
               gp_n    = gap;
               fs_n    = '0;
               idx_n   = MSB;
            end
         SEND:
            if (abort) begin
               state_n = IDLE;
               idx_n   = MSB;
            end else if (idx != '0) begin
               idx_n = idx - IW'(1);
            end else begin
               fs_n  = frames_sent + CNT_W'(1);
               idx_n = MSB;
               if (frames_sent + CNT_W'(1) == nf) begin
                  state_n = DONE;
               end else if (gp == '0) begin
                  state_n = SEND;
               end else begin
                  state_n = GAP;
                  gcnt_n  = gp - GAP_W'(1);
               end
            end
         GAP:
            if (abort) begin
               state_n = IDLE;
               idx_n   = MSB;
            end else if (gcnt == '0) begin
               state_n = SEND;
               idx_n   = MSB;
            end else begin
               gcnt_n = gcnt - GAP_W'(1);
            end
         default: state_n = IDLE;
      endcase
   end

   // Outputs are registered from the next state so the first bit appears one cycle after start.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         idx         <= MSB;
         nf          <= '0;
         gp          <= '0;
         gcnt        <= '0;
         frames_sent <= '0;
         out         <= IDLE_BIT;
         out_valid   <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
      end else begin
         state       <= state_n;
         idx         <= idx_n;
         nf          <= nf_n;
         gp          <= gp_n;
         gcnt        <= gcnt_n;
         frames_sent <= fs_n;
         out         <= (state_n == SEND) ? PAT[idx_n] : IDLE_BIT;
         out_valid   <= state_n == SEND;
         busy        <= state_n == SEND || state_n == GAP;
         done        <= state_n == DONE;
      end
   end
endmodule

// File: doc/seq_tx_0110.md
SEQ_TX_0110 -- requirements
Module: seq_tx_0110

Interface
REQ-001 Parameter PAT_W, default 4: pattern length in bits.
REQ-002 Parameter PAT, default 4'b0110: transmitted pattern, sent MSB first.
REQ-003 Parameter CNT_W, default 8: width of the frame count.
REQ-004 Parameter GAP_W, default 4: width of the inter-frame gap length.
REQ-005 Parameter IDLE_BIT, default 1'b1: line level when no pattern bit is driven.
REQ-006 clk  input  1  clock; all logic SHALL be on the rising edge.
REQ-007 rst  input  1  reset, synchronous, active-high.
REQ-008 start  input  1  request to begin a transmission, sampled in IDLE only.
REQ-009 num_frames  input  CNT_W  number of pattern frames to send, latched on accepted start.
REQ-010 gap  input  GAP_W  IDLE_BIT cycles between frames, latched on accepted start.
REQ-011 abort  input  1  terminate the transmission in progress.
REQ-012 out  output  1  registered serial data line.
REQ-013 out_valid  output  1  high while out carries a pattern bit.
REQ-014 busy  output  1  high in SEND and GAP.
REQ-015 done  output  1  one-cycle pulse when all frames have been sent.
REQ-016 frames_sent  output  CNT_W  completed frames in the current or last transmission.

Function
REQ-017 The FSM SHALL have states IDLE, SEND, GAP, DONE; all outputs SHALL be registered.
REQ-018 IDLE: start=1 with num_frames!=0 at edge N SHALL do the following at that edge: latch num_frames and gap, clear frames_sent, load bit index PAT_W-1, go to SEND.
REQ-019 The first pattern bit PAT[PAT_W-1] SHALL appear on out with out_valid=1 in the cycle following edge N (latency 1).
REQ-020 start with num_frames=0 SHALL be ignored: no state change, frames_sent unchanged.
REQ-021 start while not in IDLE SHALL be ignored.
REQ-022 SEND SHALL drive one pattern bit per cycle, MSB to LSB: out=PAT[idx], out_valid=1, busy=1.
REQ-023 On the LSB cycle, frames_sent SHALL increment by 1 at the closing edge.
REQ-024 On the LSB cycle, if frames_sent+1 == latched num_frames, the next state SHALL be DONE.
REQ-025 Otherwise, on the LSB cycle, the next state SHALL be SEND at MSB when latched gap=0 (back-to-back frames), else GAP.
REQ-026 GAP SHALL last exactly the latched gap cycles with out=IDLE_BIT, out_valid=0, busy=1, then return to SEND at MSB.
REQ-027 DONE SHALL last one cycle with done=1, busy=0, out=IDLE_BIT, out_valid=0, then go to IDLE.
REQ-028 IDLE SHALL drive out=IDLE_BIT, out_valid=0, busy=0, done=0.
REQ-029 frames_sent SHALL hold its value in IDLE until the next accepted start.
REQ-030 abort=1 in SEND or GAP SHALL force IDLE at the next edge.
REQ-031 On abort, out SHALL become IDLE_BIT, out_valid=0, done SHALL NOT pulse, and frames_sent SHALL hold the count of completed frames.
REQ-032 abort in IDLE or DONE SHALL have no effect; abort SHALL take priority over frame completion in the same cycle.
REQ-033 Changes on num_frames or gap after the accepted start SHALL NOT affect the transmission in progress.
REQ-034 Latched num_frames = 2^CNT_W-1 SHALL complete normally with no counter wrap.
REQ-035 Non-overlapping emission: every frame SHALL be sent in full, so a 0110 non-overlapping detector on out sees exactly frames_sent matches.

Reset
REQ-036 rst=1 SHALL take priority over all inputs in any state, including mid-frame.
REQ-037 At the next edge, rst=1 SHALL give state=IDLE, out=IDLE_BIT, out_valid=0, busy=0, done=0, frames_sent=0, bit index=PAT_W-1, and latched num_frames/gap=0.

Verification
REQ-038 Reset: hold rst 2 cycles with start=1 -> out=1, out_valid=0, busy=0, done=0, frames_sent=0.
REQ-039 start, num_frames=1, gap=0 -> cycles 1-4 out=0,1,1,0 with out_valid=1; cycle 5 done=1, frames_sent=1; cycle 6 IDLE.
REQ-040 num_frames=3, gap=2 -> out=0110 11 0110 11 0110 over 16 cycles, out_valid low on the gap cycles; done on cycle 17; frames_sent=3.
REQ-041 num_frames=2, gap=0 -> out=01100110 in 8 consecutive cycles; a non-overlapping 0110 detector fed out pulses exactly twice.
REQ-042 num_frames=4, abort on the 3rd bit of frame 2 -> IDLE next edge, no done pulse, frames_sent=1; start during busy and start with num_frames=0 are both ignored.
REQ-043 rst asserted on the 2nd bit of frame 1 -> next cycle: all reset values, frames_sent=0; a new start then behaves as in REQ-039.
